// File: rtl/vga_pkg.sv
// vga_pkg -- shared VGA constants and types.
//   Default 640x480@60 timing (in pixels / lines), the coordinate width used
//   by the timing generator and the pixel-source stage, and a small range
//   helper for unsigned coordinate compares.
package vga_pkg;

  localparam int COORD_W = 10;

  localparam int H_ACT_DEF  = 640;
  localparam int H_FP_DEF   = 16;
  localparam int H_SYNC_DEF = 96;
  localparam int H_BP_DEF   = 48;

  localparam int V_ACT_DEF  = 480;
  localparam int V_FP_DEF   = 10;
  localparam int V_SYNC_DEF = 2;
  localparam int V_BP_DEF   = 33;

  typedef logic [COORD_W-1:0] coord_t;

  // True when lo <= v < hi, all operands unsigned at coordinate width.
  function automatic logic in_range(input coord_t v, input coord_t lo, input coord_t hi);
    return (v >= lo) && (v < hi);
  endfunction

endpackage

// File: rtl/vga_axis_ctr.sv
// vga_axis_ctr -- one axis (horizontal or vertical) of the VGA raster.
//   Counts 0..TOTAL-1 on every enabled clock and wraps to 0.
// Ports:
//   clk   - rising-edge clock
//   rst   - synchronous active-high reset, clears the count
//   en    - advance enable
//   count - current position
//   wrap  - high on the enabled cycle where count is TOTAL-1 (next edge wraps)
module vga_axis_ctr
  import vga_pkg::*;
#(
  parameter int TOTAL = 800
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   en,
  output coord_t count,
  output logic   wrap
);

  localparam coord_t LAST = coord_t'(TOTAL - 1);

  coord_t count_q;
  coord_t count_d;

  always_comb begin
    count_d = count_q;
    if (en) begin
      count_d = (count_q == LAST) ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign wrap  = en && (count_q == LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen -- VGA raster timing generator.
//   Two chained axis counters produce the (x,y) raster position; sync,
//   active and frame-start are decoded combinationally from the counter
//   registers so they line up with x/y with no extra latency.
// Ports:
//   clk         - system clock, all flops on its rising edge
//   rst         - synchronous active-high reset (priority over pix_tick)
//   x, y        - current horizontal / vertical position
//   hsync       - active-low horizontal sync
//   vsync       - active-low vertical sync
//   active      - high inside the visible area
//   pix_tick    - high on cycles where the counters advance
//   frame_start - high on the advancing cycle at (0,0)
// Build option:
//   VGA_TIMING_PIXDIV_EN - when defined, a divide-by-2 phase flop gates
//   pix_tick so the raster advances every second clk (e.g. 25 MHz pixel
//   rate from 50 MHz). Undefined: pix_tick is tied high.
// Parameters must keep H_TOT and V_TOT at or below 1024 (10-bit counters).
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACT  = H_ACT_DEF,
  parameter int H_FP   = H_FP_DEF,
  parameter int H_SYNC = H_SYNC_DEF,
  parameter int H_BP   = H_BP_DEF,
  parameter int V_ACT  = V_ACT_DEF,
  parameter int V_FP   = V_FP_DEF,
  parameter int V_SYNC = V_SYNC_DEF,
  parameter int V_BP   = V_BP_DEF
) (
  input  logic               clk,
  input  logic               rst,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               hsync,
  output logic               vsync,
  output logic               active,
  output logic               pix_tick,
  output logic               frame_start
);

  localparam int H_TOT = H_ACT + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACT + V_FP + V_SYNC + V_BP;

  localparam coord_t HS_START = coord_t'(H_ACT + H_FP);
  localparam coord_t HS_END   = coord_t'(H_ACT + H_FP + H_SYNC);
  localparam coord_t VS_START = coord_t'(V_ACT + V_FP);
  localparam coord_t VS_END   = coord_t'(V_ACT + V_FP + V_SYNC);

  coord_t h_count;
  coord_t v_count;
  logic   h_wrap;
  logic   v_wrap_unused;

`ifdef VGA_TIMING_PIXDIV_EN
  // Phase starts at 0 out of reset, so the first advance lands on the
  // second edge after release.
  logic phase_q;
  logic phase_d;

  always_comb begin
    phase_d = ~phase_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= 1'b0;
    end else begin
      phase_q <= phase_d;
    end
  end

  assign pix_tick = phase_q;
`else
  assign pix_tick = 1'b1;
`endif

  vga_axis_ctr #(
    .TOTAL(H_TOT)
  ) u_h_ctr (
    .clk  (clk),
    .rst  (rst),
    .en   (pix_tick),
    .count(h_count),
    .wrap (h_wrap)
  );

  // The vertical counter only moves on the horizontal wrap tick, so the
  // (last,last) -> (0,0) transition happens in a single tick.
  vga_axis_ctr #(
    .TOTAL(V_TOT)
  ) u_v_ctr (
    .clk  (clk),
    .rst  (rst),
    .en   (h_wrap),
    .count(v_count),
    .wrap (v_wrap_unused)
  );

  assign x           = h_count;
  assign y           = v_count;
  assign hsync       = ~in_range(h_count, HS_START, HS_END);
  assign vsync       = ~in_range(v_count, VS_START, VS_END);
  assign active      = (h_count < coord_t'(H_ACT)) && (v_count < coord_t'(V_ACT));
  assign frame_start = pix_tick && (h_count == '0) && (v_count == '0);

endmodule

// File: tb/tb_vga_timing_gen.sv
module tb_vga_timing_gen;

`ifdef VGA_TIMING_PIXDIV_EN
  localparam bit DIV = 1'b1;
`else
  localparam bit DIV = 1'b0;
`endif
  localparam int CPT = DIV ? 2 : 1;  // clocks per pixel tick

  // Full-size raster (default parameters)
  localparam int L_HACT = 640, L_HFP = 16, L_HS = 96, L_HBP = 48;
  localparam int L_VACT = 480, L_VFP = 10, L_VS = 2,  L_VBP = 33;
  localparam int L_H = L_HACT + L_HFP + L_HS + L_HBP;
  localparam int L_V = L_VACT + L_VFP + L_VS + L_VBP;
  localparam int L_FRAME = L_H * L_V;

  // Shrunken raster so whole frames fit a short run
  localparam int S_HACT = 40, S_HFP = 4, S_HS = 8, S_HBP = 6;
  localparam int S_VACT = 30, S_VFP = 3, S_VS = 2, S_VBP = 4;
  localparam int S_H = S_HACT + S_HFP + S_HS + S_HBP;
  localparam int S_V = S_VACT + S_VFP + S_VS + S_VBP;
  localparam int S_FRAME = S_H * S_V;

  logic clk = 1'b0;
  logic rst_l = 1'b1;
  logic rst_s = 1'b1;
  logic [9:0] x_l, y_l, x_s, y_s;
  logic hsync_l, vsync_l, active_l, pix_tick_l, frame_start_l;
  logic hsync_s, vsync_s, active_s, pix_tick_s, frame_start_s;

  int compared = 0;
  int mismatched = 0;

  // Reference model: linear pixel index within the frame plus divider phase.
  int n_l = 0, n_s = 0;
  bit ph_l = 1'b0, ph_s = 1'b0;

  always #5 clk = ~clk;

  vga_timing_gen dut_l (
    .clk(clk), .rst(rst_l), .x(x_l), .y(y_l), .hsync(hsync_l), .vsync(vsync_l),
    .active(active_l), .pix_tick(pix_tick_l), .frame_start(frame_start_l)
  );

  vga_timing_gen #(
    .H_ACT(S_HACT), .H_FP(S_HFP), .H_SYNC(S_HS), .H_BP(S_HBP),
    .V_ACT(S_VACT), .V_FP(S_VFP), .V_SYNC(S_VS), .V_BP(S_VBP)
  ) dut_s (
    .clk(clk), .rst(rst_s), .x(x_s), .y(y_s), .hsync(hsync_s), .vsync(vsync_s),
    .active(active_s), .pix_tick(pix_tick_s), .frame_start(frame_start_s)
  );

  function automatic bit e_hs(int n, int htot, int hact, int hfp, int hs);
    int px = n % htot;
    return !(px >= hact + hfp && px < hact + hfp + hs);
  endfunction

  function automatic bit e_vs(int n, int htot, int vact, int vfp, int vs);
    int ln = n / htot;
    return !(ln >= vact + vfp && ln < vact + vfp + vs);
  endfunction

  function automatic bit e_act(int n, int htot, int hact, int vact);
    return ((n % htot) < hact) && ((n / htot) < vact);
  endfunction

  // One clock edge: advance both models, then settle to the sample point.
  task automatic tick();
    bit tl, ts;
    @(posedge clk);
    tl = DIV ? ph_l : 1'b1;
    ts = DIV ? ph_s : 1'b1;
    if (rst_l) begin n_l = 0; ph_l = 1'b0; end
    else begin if (tl) n_l = (n_l + 1) % L_FRAME; ph_l = ~ph_l; end
    if (rst_s) begin n_s = 0; ph_s = 1'b0; end
    else begin if (ts) n_s = (n_s + 1) % S_FRAME; ph_s = ~ph_s; end
    #1;
  endtask

  task automatic test_reset();
    bit ept;
    rst_l = 1'b1; tick(); tick(); rst_l = 1'b0;
    repeat ($urandom_range(100, 700)) tick();
    compared++;
    if (x_l !== 10'(n_l % L_H)) begin
      mismatched++; $display("FAIL reset_premid_x got=%0d exp=%0d", x_l, n_l % L_H);
    end
    rst_l = 1'b1;
    ept = DIV ? 1'b0 : 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      compared++; if (x_l !== 10'd0) begin mismatched++; $display("FAIL reset_x cyc=%0d got=%0d exp=0", i, x_l); end
      compared++; if (y_l !== 10'd0) begin mismatched++; $display("FAIL reset_y cyc=%0d got=%0d exp=0", i, y_l); end
      compared++; if (hsync_l !== 1'b1) begin mismatched++; $display("FAIL reset_hsync cyc=%0d got=%b exp=1", i, hsync_l); end
      compared++; if (vsync_l !== 1'b1) begin mismatched++; $display("FAIL reset_vsync cyc=%0d got=%b exp=1", i, vsync_l); end
      compared++; if (active_l !== 1'b1) begin mismatched++; $display("FAIL reset_active cyc=%0d got=%b exp=1", i, active_l); end
      compared++; if (pix_tick_l !== ept) begin mismatched++; $display("FAIL reset_pix_tick cyc=%0d got=%b exp=%b", i, pix_tick_l, ept); end
      compared++; if (frame_start_l !== ept) begin mismatched++; $display("FAIL reset_frame_start cyc=%0d got=%b exp=%b", i, frame_start_l, ept); end
    end
    rst_l = 1'b0;
  endtask

  task automatic test_line_timing();
    int bad = 0, hs_low = 0, hs_first = -1, act_first = -1;
    string first = "";
    bit ept;
    rst_l = 1'b1; tick(); rst_l = 1'b0;
    for (int c = 0; c < CPT * (L_H + 1); c++) begin
      ept = DIV ? ph_l : 1'b1;
      if (x_l !== 10'(n_l % L_H) || y_l !== 10'(n_l / L_H) ||
          hsync_l !== e_hs(n_l, L_H, L_HACT, L_HFP, L_HS) ||
          vsync_l !== e_vs(n_l, L_H, L_VACT, L_VFP, L_VS) ||
          active_l !== e_act(n_l, L_H, L_HACT, L_VACT) ||
          pix_tick_l !== ept || frame_start_l !== (ept && n_l == 0)) begin
        bad++;
        if (bad == 1) first = $sformatf("c=%0d x=%0d y=%0d hs=%b act=%b pt=%b fs=%b model_n=%0d",
                                        c, x_l, y_l, hsync_l, active_l, pix_tick_l, frame_start_l, n_l);
      end
      if (pix_tick_l === 1'b1 && y_l === 10'd0) begin
        if (hsync_l === 1'b0) begin hs_low++; if (hs_first < 0) hs_first = int'(x_l); end
        if (active_l === 1'b0 && act_first < 0) act_first = int'(x_l);
      end
      tick();
    end
    compared++; if (bad !== 0) begin mismatched++; $display("FAIL line_sweep bad=%0d exp=0 first: %s", bad, first); end
    compared++; if (hs_low !== L_HS) begin mismatched++; $display("FAIL line_hsync_width got=%0d exp=%0d", hs_low, L_HS); end
    compared++; if (hs_first !== L_HACT + L_HFP) begin mismatched++; $display("FAIL line_hsync_start got=%0d exp=%0d", hs_first, L_HACT + L_HFP); end
    compared++; if (act_first !== L_HACT) begin mismatched++; $display("FAIL line_active_end got=%0d exp=%0d", act_first, L_HACT); end
    compared++; if (x_l !== 10'd1 || y_l !== 10'd1) begin mismatched++; $display("FAIL line_wrap got=(%0d,%0d) exp=(1,1)", x_l, y_l); end
  endtask

  task automatic test_divider();
    rst_l = 1'b1; tick(); tick(); rst_l = 1'b0;
    for (int k = 0; k < 8; k++) begin
      compared++;
      if (pix_tick_l !== (DIV ? 1'(k % 2) : 1'b1)) begin
        mismatched++; $display("FAIL div_pix_tick k=%0d got=%b exp=%b", k, pix_tick_l, DIV ? 1'(k % 2) : 1'b1);
      end
      compared++;
      if (x_l !== 10'(DIV ? k / 2 : k)) begin
        mismatched++; $display("FAIL div_x k=%0d got=%0d exp=%0d", k, x_l, DIV ? k / 2 : k);
      end
      tick();
    end
  endtask

  task automatic test_frame_wrap();
    int ticks = 0, first = -1, second = -1, fs_cycles = 0, fs_bad = 0;
    rst_s = 1'b1; tick(); rst_s = 1'b0;
    for (int c = 0; c < CPT * S_FRAME + 4 && n_s != S_FRAME - 1; c++) tick();
    compared++;
    if (x_s !== 10'(S_H - 1) || y_s !== 10'(S_V - 1)) begin
      mismatched++; $display("FAIL frame_last got=(%0d,%0d) exp=(%0d,%0d)", x_s, y_s, S_H - 1, S_V - 1);
    end
    for (int c = 0; c < 3 && n_s == S_FRAME - 1; c++) tick();
    compared++;
    if (x_s !== 10'd0 || y_s !== 10'd0) begin
      mismatched++; $display("FAIL frame_wrap got=(%0d,%0d) exp=(0,0)", x_s, y_s);
    end
    for (int c = 0; c < CPT * (S_FRAME + 2) + 4; c++) begin
      if (frame_start_s === 1'b1) fs_cycles++;
      if (frame_start_s === 1'b1 && pix_tick_s !== 1'b1) fs_bad++;
      if (pix_tick_s === 1'b1) begin
        if (frame_start_s === 1'b1) begin
          if (first < 0) first = ticks;
          else begin second = ticks; break; end
        end
        ticks++;
      end
      tick();
    end
    compared++;
    if (second < 0) begin
      mismatched++; $display("FAIL frame_period timeout first=%0d second=%0d exp_period=%0d", first, second, S_FRAME);
    end else if (second - first !== S_FRAME) begin
      mismatched++; $display("FAIL frame_period got=%0d exp=%0d", second - first, S_FRAME);
    end
    compared++; if (fs_cycles !== 2) begin mismatched++; $display("FAIL frame_start_count got=%0d exp=2", fs_cycles); end
    compared++; if (fs_bad !== 0) begin mismatched++; $display("FAIL frame_start_no_tick got=%0d exp=0", fs_bad); end
  endtask

  task automatic test_vsync();
    int vs_low = 0, ymin = 1 << 20, ymax = -1;
    rst_s = 1'b1; tick(); rst_s = 1'b0;
    for (int c = 0; c < CPT * S_FRAME; c++) begin
      if (pix_tick_s === 1'b1 && vsync_s === 1'b0) begin
        vs_low++;
        if (int'(y_s) < ymin) ymin = int'(y_s);
        if (int'(y_s) > ymax) ymax = int'(y_s);
      end
      tick();
    end
    compared++; if (vs_low !== S_VS * S_H) begin mismatched++; $display("FAIL vsync_width got=%0d exp=%0d", vs_low, S_VS * S_H); end
    compared++; if (ymin !== S_VACT + S_VFP) begin mismatched++; $display("FAIL vsync_first_line got=%0d exp=%0d", ymin, S_VACT + S_VFP); end
    compared++; if (ymax !== S_VACT + S_VFP + S_VS - 1) begin mismatched++; $display("FAIL vsync_last_line got=%0d exp=%0d", ymax, S_VACT + S_VFP + S_VS - 1); end
    compared++; if (x_s !== 10'd0 || y_s !== 10'd0) begin mismatched++; $display("FAIL vsync_frame_end got=(%0d,%0d) exp=(0,0)", x_s, y_s); end
  endtask

  task automatic test_mid_reset();
    int vy, hx, tgt, bad = 0;
    string first = "";
    bit ept;
    rst_s = 1'b1; tick(); rst_s = 1'b0;
    vy = $urandom_range(S_V / 3, S_V - 2);
    hx = $urandom_range(1, S_H - 2);
    tgt = vy * S_H + hx;
    for (int c = 0; c < CPT * S_FRAME + 4 && n_s != tgt; c++) tick();
    compared++;
    if (x_s !== 10'(hx) || y_s !== 10'(vy)) begin
      mismatched++; $display("FAIL midrst_reach got=(%0d,%0d) exp=(%0d,%0d)", x_s, y_s, hx, vy);
    end
    rst_s = 1'b1; tick(); rst_s = 1'b0;
    compared++;
    if (x_s !== 10'd0 || y_s !== 10'd0 || hsync_s !== 1'b1 || vsync_s !== 1'b1 || active_s !== 1'b1) begin
      mismatched++; $display("FAIL midrst_zero got=(%0d,%0d) hs=%b vs=%b act=%b exp=(0,0) 1 1 1",
                             x_s, y_s, hsync_s, vsync_s, active_s);
    end
    repeat ($urandom_range(200, 600)) begin
      tick();
      ept = DIV ? ph_s : 1'b1;
      if (x_s !== 10'(n_s % S_H) || y_s !== 10'(n_s / S_H) || pix_tick_s !== ept) begin
        bad++;
        if (bad == 1) first = $sformatf("x=%0d y=%0d pt=%b model=(%0d,%0d)", x_s, y_s, pix_tick_s, n_s % S_H, n_s / S_H);
      end
    end
    compared++; if (bad !== 0) begin mismatched++; $display("FAIL midrst_resume bad=%0d exp=0 first: %s", bad, first); end
  endtask

  task automatic test_random();
    int bad = 0, hold = 0;
    string first = "";
    bit ept;
    for (int c = 0; c < 4000; c++) begin
      if (hold > 0) hold--;
      else if ($urandom_range(0, 299) == 0) hold = $urandom_range(1, 3);
      rst_s = (hold > 0);
      tick();
      ept = DIV ? ph_s : 1'b1;
      if (x_s !== 10'(n_s % S_H) || y_s !== 10'(n_s / S_H) ||
          hsync_s !== e_hs(n_s, S_H, S_HACT, S_HFP, S_HS) ||
          vsync_s !== e_vs(n_s, S_H, S_VACT, S_VFP, S_VS) ||
          active_s !== e_act(n_s, S_H, S_HACT, S_VACT) ||
          pix_tick_s !== ept || frame_start_s !== (ept && n_s == 0)) begin
        bad++;
        if (bad == 1) first = $sformatf("c=%0d x=%0d y=%0d hs=%b vs=%b act=%b pt=%b fs=%b model_n=%0d",
                                        c, x_s, y_s, hsync_s, vsync_s, active_s, pix_tick_s, frame_start_s, n_s);
      end
    end
    rst_s = 1'b0;
    compared++; if (bad !== 0) begin mismatched++; $display("FAIL random_sweep bad=%0d exp=0 first: %s", bad, first); end
  endtask

  initial begin
    tick(); tick();
    rst_l = 1'b0; rst_s = 1'b0;
    test_reset();
    test_line_timing();
    test_divider();
    test_frame_wrap();
    test_vsync();
    test_mid_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
